prog_clock_divider: RTL and testbench

Runtime-programmable clock divider for the alarm-clock timebase. It generalises the fixed divide-by-N prescaler with a parametrised counter width and a runtime divide ratio and high time. Loads are shadowed and applied glitch-free at the period boundary, and an enable freezes the divider. It sits between the board clock and the seconds/minutes counters, which consume `pulse` as a one-cycle tick and `clkout` as a shaped divided clock.

---
 rtl/prog_clock_divider.sv | 170 +++++++++++++++++
 tb/tb_prog_clock_divider.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// prog_clock_divider
// Runtime-programmable divider for the alarm-clock timebase. The counter
// runs 0..div_act-1. clkout is low for div_act-high_act cycles and then
// high for high_act cycles. pulse is a one-cycle tick in the cycle where
// count is 0 after a wrap. New divisor and high-time values are staged in
// a shadow and only take effect on a period boundary, so clkout never
// glitches mid-period.
//
// Load protocol: load is sampled on every rising edge. A load whose values
// are legal (div_in >= 2 and 1 <= high_in <= div_in-1) is written to the
// shadow and raises busy on the next edge. A later legal load overwrites
// the shadow; the last one wins. The shadow becomes active at the next
// wrap, or on the next edge if en is low. In that cycle load_ack pulses
// and busy falls. An illegal load pulses div_err for one cycle and leaves
// every other register unchanged. No input reaches an output without
// passing through a register.
//
// Parameters are expected to satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1 and
// 1 <= DEFAULT_HIGH <= DEFAULT_DIV-1.
module prog_clock_divider #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_DIV  = 6,
    parameter int DEFAULT_HIGH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             busy,
    output logic             load_ack,
    output logic             div_err,
    output logic             pulse,
    output logic             clkout,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    // Active divisor/high time, shadow copies and the pending flag
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] div_sh;
    logic [WIDTH-1:0] high_sh;
    logic             pend;

    // Counter and registered outputs
    logic [WIDTH-1:0] cnt;
    logic             pulse_q;
    logic             clkout_q;
    logic             ack_q;
    logic             err_q;

    // Combinational helpers
    logic             load_valid;
    logic             load_take;
    logic             load_reject;
    logic             wrap;
    logic             apply_run;
    logic             apply_hold;
    logic             apply_any;
    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] high_eff;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH-1:0] cnt_next;
    logic             clk_next;

    // Validation, wrap detection and next-count/clkout computation
    always_comb begin
        load_valid = 1'b0;
        if ((div_in >= TWO) && (high_in != '0) && (high_in < div_in)) begin
            load_valid = 1'b1;
        end
        load_take   = load && load_valid;
        load_reject = load && !load_valid;

        // div_act >= 2 always, so div_act-1 never underflows
        wrap = (cnt == (div_act - ONE));

        // Shadow becomes active at a running wrap, or at once when frozen
        apply_run  = en && wrap && pend;
        apply_hold = !en && pend;
        apply_any  = apply_run || apply_hold;

        // At an applying wrap, clkout for count 0 uses the incoming values
        div_eff  = apply_run ? div_sh  : div_act;
        high_eff = apply_run ? high_sh : high_act;
        low_len  = div_eff - high_eff;

        cnt_next = wrap ? '0 : (cnt + ONE);
        // low_len >= 1, so count 0 always gives clkout low
        clk_next = (cnt_next >= low_len);
    end

    // Counter, divided clock and period tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            pulse_q  <= 1'b0;
            clkout_q <= 1'b0;
        end else if (en) begin
            cnt      <= cnt_next;
            pulse_q  <= wrap;
            clkout_q <= clk_next;
        end else begin
            pulse_q <= 1'b0;
            if (pend) begin
                cnt      <= '0;
                clkout_q <= 1'b0;
            end
        end
    end

    // Active divisor/high time, refreshed from the shadow on apply
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_act  <= DIV_RST;
            high_act <= HIGH_RST;
        end else if (apply_any) begin
            div_act  <= div_sh;
            high_act <= high_sh;
        end
    end

    // Shadow capture and pending flag; a load on the apply edge stays pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_sh  <= DIV_RST;
            high_sh <= HIGH_RST;
            pend    <= 1'b0;
        end else if (load_take) begin
            div_sh  <= div_in;
            high_sh <= high_in;
            pend    <= 1'b1;
        end else if (apply_any) begin
            pend    <= 1'b0;
        end
    end

    // One-cycle status pulses for apply and rejected loads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= apply_any;
            err_q <= load_reject;
        end
    end

    // The counter stays inside the active period
    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst)
        cnt < div_act);

    // The active high time always leaves at least one low cycle
    a_high_legal: assert property (@(posedge clk) disable iff (!rst)
        (high_act != '0) && (high_act < div_act));

    assign busy     = pend;
    assign load_ack = ack_q;
    assign div_err  = err_q;
    assign pulse    = pulse_q;
    assign clkout   = clkout_q;
    assign count    = cnt;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider with the default parameters (D=6, H=3).
// Each scenario task queues stimulus and expected outputs together. It
// then steps one clock per entry and compares at the falling edge.
module tb_prog_clock_divider;

  localparam int W  = 8;
  localparam int EW = W + 5;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] div_in;
  logic [W-1:0] high_in;
  logic         busy;
  logic         load_ack;
  logic         div_err;
  logic         pulse;
  logic         clkout;
  logic [W-1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic         en;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] h;
  } stim_t;

  stim_t         stim_q[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_vec;

  assign obs_vec = {count, clkout, pulse, busy, load_ack, div_err};

  always #5 clk = ~clk;

  prog_clock_divider #(
    .WIDTH       (W),
    .DEFAULT_DIV (6),
    .DEFAULT_HIGH(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .high_in (high_in),
    .busy    (busy),
    .load_ack(load_ack),
    .div_err (div_err),
    .pulse   (pulse),
    .clkout  (clkout),
    .count   (count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic push(input logic s_en, input logic s_load, input int s_d, input int s_h,
                      input int e_cnt, input logic e_clk, input logic e_pls,
                      input logic e_bsy, input logic e_ack, input logic e_err);
    stim_t s;
    s.en   = s_en;
    s.load = s_load;
    s.d    = W'(s_d);
    s.h    = W'(s_h);
    stim_q.push_back(s);
    exp_q.push_back({W'(e_cnt), e_clk, e_pls, e_bsy, e_ack, e_err});
  endtask

  task automatic drive_next();
    stim_t s;
    s = stim_q.pop_front();
    en      = s.en;
    load    = s.load;
    div_in  = s.d;
    high_in = s.h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    div_in  = '0;
    high_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== '0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d got %b exp %b", i, obs_vec, {EW{1'b0}});
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL reset_release got %b exp %b", obs_vec, {EW{1'b0}});
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_defaults();
    int            step;
    int            c;
    logic [EW-1:0] e;
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      c = i % 6;
      push(1'b1, 1'b0, 0, 0, c, c >= 3, c == 0, 1'b0, 1'b0, 1'b0);
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL defaults step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_load_apply();
    int            step;
    int            c;
    int            m;
    logic          ld;
    logic [EW-1:0] e;
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      ld = (i == 3);
      if (i < 6) begin
        c = i;
        push(1'b1, ld, ld ? 10 : 0, ld ? 2 : 0, c, c >= 3, 1'b0, i >= 3, 1'b0, 1'b0);
      end else begin
        m = i - 6;
        c = m % 10;
        push(1'b1, ld, 0, 0, c, c >= 8, c == 0, 1'b0, m == 0, 1'b0);
      end
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL load_apply step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_invalid();
    int            step;
    int            c;
    int            d;
    int            h;
    logic          ld;
    logic [EW-1:0] e;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      ld = 1'b1;
      case (i)
        1:       begin d = 1; h = 0; end
        3:       begin d = 5; h = 5; end
        5:       begin d = 0; h = 0; end
        7:       begin d = 7; h = 0; end
        9:       begin d = 3; h = 9; end
        default: begin d = 0; h = 0; ld = 1'b0; end
      endcase
      c = i % 6;
      push(1'b1, ld, d, h, c, c >= 3, c == 0, 1'b0, 1'b0, ld);
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL invalid step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_hold();
    int            step;
    int            c;
    int            m;
    logic [EW-1:0] e;
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      if (i <= 4) begin
        push(1'b1, 1'b0, 0, 0, i, i >= 3, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (i <= 11) begin
        push(1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (i == 12) begin
        push(1'b1, 1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (i == 13) begin
        push(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end else if (i <= 15) begin
        push(1'b1, 1'b0, 0, 0, i - 13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (i == 16) begin
        push(1'b0, 1'b1, 2, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (i == 17) begin
        push(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        m = i - 17;
        c = m % 2;
        push(1'b1, 1'b0, 0, 0, c, c >= 1, c == 0, 1'b0, 1'b0, 1'b0);
      end
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL hold step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int            step;
    int            c;
    int            m;
    int            d;
    int            h;
    logic          ld;
    logic [EW-1:0] e;
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      ld = (i == 6) || (i == 7);
      d  = (i == 6) ? 8 : ((i == 7) ? 4 : 0);
      h  = (i == 6) ? 1 : ((i == 7) ? 3 : 0);
      if (i <= 11) begin
        c = i % 6;
        push(1'b1, ld, d, h, c, c >= 3, c == 0, i >= 6, 1'b0, 1'b0);
      end else begin
        m = i - 12;
        c = m % 4;
        push(1'b1, ld, d, h, c, c >= 1, c == 0, 1'b0, m == 0, 1'b0);
      end
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL back_to_back step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    int            step;
    int            c;
    logic          ld;
    logic [EW-1:0] e;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      ld = (i == 1);
      push(1'b1, ld, ld ? 10 : 0, ld ? 2 : 0, i, i >= 3, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL pre_reset step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
    // reset in the middle of the low clock phase, away from any edge
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL async_reset got %b exp %b", obs_vec, {EW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      c = i % 6;
      push(1'b1, 1'b0, 0, 0, c, c >= 3, c == 0, 1'b0, 1'b0, 1'b0);
    end
    step = 0;
    while (exp_q.size() > 0) begin
      drive_next();
      step++;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        failures++;
        $display("FAIL post_reset step %0d got cnt/clk/pls/bsy/ack/err=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                 step, count, clkout, pulse, busy, load_ack, div_err,
                 e[EW-1:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  // sequence and final report
  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    div_in  = '0;
    high_in = '0;
    test_reset();
    test_defaults();
    test_load_apply();
    test_invalid();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
